// File: rtl/spi_fl_pkg.sv
// Shared definitions for the SPI flash command sequencer: request op codes,
// flash opcodes, transfer types understood by spi_master_fl, FSM states and
// the helper that decides what the master-side fields look like in each state.
package spi_fl_pkg;

    // Request operations as presented on req_op
    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_PROGRAM = 2'b01,
        OP_ERASE   = 2'b10,
        OP_STATUS  = 2'b11
    } op_e;

    // Serial flash opcodes
    localparam logic [7:0] FL_CMD_WREN       = 8'h06;
    localparam logic [7:0] FL_CMD_FAST_READ  = 8'h0B;
    localparam logic [7:0] FL_CMD_PAGE_PROG  = 8'h02;
    localparam logic [7:0] FL_CMD_SECT_ERASE = 8'h20;
    localparam logic [7:0] FL_CMD_READ_SR    = 8'h05;

    // Transfer shapes understood by spi_master_fl
    typedef enum logic [2:0] {
        CT_CMD_ONLY    = 3'd0,
        CT_CMD_ADDR    = 3'd1,
        CT_CMD_ADDR_TX = 3'd2,
        CT_CMD_ADDR_RX = 3'd3,
        CT_CMD_RX      = 3'd4,
        CT_CMD_TX      = 3'd5
    } commtype_e;

    // Sequencer states
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WREN      = 4'd1,
        WREN_WAIT = 4'd2,
        CMD       = 4'd3,
        CMD_WAIT  = 4'd4,
        GAP       = 4'd5,
        POLL      = 4'd6,
        POLL_WAIT = 4'd7,
        RESP      = 4'd8
    } state_e;

    // Master-side fields that change from one transfer to the next
    typedef struct packed {
        logic [7:0]  command;
        logic [23:0] address;
        logic [31:0] data_in;
        commtype_e   commtype;
        logic [6:0]  ndata_bits;
        logic [3:0]  dummy_cycles;
    } fields_t;

    // An issue state and its _WAIT state map to the same fields, so the
    // fields stay frozen from the validflag pulse until the transfer ends.
    function automatic fields_t master_fields(
        input state_e      st,
        input op_e         op,
        input logic [23:0] addr,
        input logic [31:0] wdata,
        input logic [3:0]  rd_dummy
    );
        fields_t f;
        f = '0;
        case (st)
            WREN, WREN_WAIT: begin
                f.command  = FL_CMD_WREN;
                f.commtype = CT_CMD_ONLY;
            end
            CMD, CMD_WAIT: begin
                case (op)
                    OP_READ: begin
                        f.command      = FL_CMD_FAST_READ;
                        f.address      = addr;
                        f.commtype     = CT_CMD_ADDR_RX;
                        f.ndata_bits   = 7'd32;
                        f.dummy_cycles = rd_dummy;
                    end
                    OP_PROGRAM: begin
                        f.command    = FL_CMD_PAGE_PROG;
                        f.address    = addr;
                        f.data_in    = wdata;
                        f.commtype   = CT_CMD_ADDR_TX;
                        f.ndata_bits = 7'd32;
                    end
                    OP_ERASE: begin
                        f.command  = FL_CMD_SECT_ERASE;
                        f.address  = addr;
                        f.commtype = CT_CMD_ADDR;
                    end
                    default: begin
                        f.command    = FL_CMD_READ_SR;
                        f.commtype   = CT_CMD_RX;
                        f.ndata_bits = 7'd8;
                    end
                endcase
            end
            POLL, POLL_WAIT: begin
                f.command    = FL_CMD_READ_SR;
                f.commtype   = CT_CMD_RX;
                f.ndata_bits = 7'd8;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/spi_fl_poll_timer.sv
// Gap timer between status polls and the count of polls issued for the
// current program/erase operation.
module spi_fl_poll_timer
    import spi_fl_pkg::*;
#(
    parameter int POLL_MAX = 4096,
    parameter int POLL_GAP = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic gap_run_i,
    input  logic poll_clr_i,
    input  logic poll_inc_i,
    output logic gap_done_o,
    output logic poll_limit_o
);

    localparam int GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
    localparam int CNT_W = (POLL_MAX < 1) ? 1 : $clog2(POLL_MAX + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_MAX);

    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;

    assign gap_done_o   = gap_run_i && (gap_cnt_q == GAP_LAST);
    assign poll_limit_o = (poll_cnt_q == CNT_MAX);

    // Gap count runs only while the sequencer sits in GAP; poll count saturates
    always_comb begin
        gap_cnt_d  = '0;
        poll_cnt_d = poll_cnt_q;
        if (gap_run_i && !gap_done_o) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end
        if (poll_clr_i) begin
            poll_cnt_d = '0;
        end else if (poll_inc_i && !poll_limit_o) begin
            poll_cnt_d = poll_cnt_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_q  <= '0;
            poll_cnt_q <= '0;
        end else begin
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end

endmodule

// File: rtl/spi_fl_cmd_seq.sv
// Serial flash command sequencer: turns READ / PROGRAM / ERASE / STATUS
// requests into spi_master_fl transfers, including write-enable and
// busy-polling for the operations that modify the array.
module spi_fl_cmd_seq
    import spi_fl_pkg::*;
#(
    parameter int POLL_MAX = 4096,
    parameter int POLL_GAP = 16,
    parameter int RD_DUMMY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [23:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic [7:0]  command_o,
    output logic [23:0] address_o,
    output logic [31:0] data_in_o,
    output logic [2:0]  commtype_o,
    output logic [6:0]  ndata_bits_o,
    output logic [3:0]  dummy_cycles_o,
    output logic [9:0]  frame_struct_o,
    output logic [1:0]  xipbit_en_o,
    output logic [1:0]  spimode_o,
    output logic        manualframe_en_o,
    output logic        validflag_o,
    input  logic [31:0] data_out_i,
    input  logic        validflag_out_i,
    input  logic        tready_i
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    fields_t     fields_q, fields_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        issue;
    logic        poll_clr;
    logic        poll_inc;
    logic        gap_done;
    logic        poll_limit;

    spi_fl_poll_timer #(
        .POLL_MAX(POLL_MAX),
        .POLL_GAP(POLL_GAP)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .gap_run_i   (state_q == GAP),
        .poll_clr_i  (poll_clr),
        .poll_inc_i  (poll_inc),
        .gap_done_o  (gap_done),
        .poll_limit_o(poll_limit)
    );

    assign req_ready_o      = (state_q == IDLE);
    assign rsp_valid_o      = (state_q == RESP);
    assign rsp_data_o       = rsp_data_q;
    assign rsp_err_o        = rsp_err_q;
    assign validflag_o      = issue;
    assign command_o        = fields_q.command;
    assign address_o        = fields_q.address;
    assign data_in_o        = fields_q.data_in;
    assign commtype_o       = fields_q.commtype;
    assign ndata_bits_o     = fields_q.ndata_bits;
    assign dummy_cycles_o   = fields_q.dummy_cycles;
    assign frame_struct_o   = '0;
    assign xipbit_en_o      = '0;
    assign spimode_o        = '0;
    assign manualframe_en_o = 1'b0;

    // Next-state logic: request latch, transfer issue, completion handling
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        issue      = 1'b0;
        poll_clr   = 1'b0;
        poll_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d    = op_e'(req_op_i);
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (op_e'(req_op_i) == OP_PROGRAM || op_e'(req_op_i) == OP_ERASE) begin
                        state_d = WREN;
                    end else begin
                        state_d = CMD;
                    end
                end
            end
            WREN: begin
                if (tready_i) begin
                    issue   = 1'b1;
                    state_d = WREN_WAIT;
                end
            end
            WREN_WAIT: begin
                if (validflag_out_i) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (tready_i) begin
                    issue   = 1'b1;
                    state_d = CMD_WAIT;
                end
            end
            CMD_WAIT: begin
                if (validflag_out_i) begin
                    case (op_q)
                        OP_READ: begin
                            rsp_data_d = data_out_i;
                            rsp_err_d  = 1'b0;
                            state_d    = RESP;
                        end
                        OP_STATUS: begin
                            rsp_data_d = {24'h0, data_out_i[7:0]};
                            rsp_err_d  = 1'b0;
                            state_d    = RESP;
                        end
                        default: begin
                            poll_clr = 1'b1;
                            state_d  = GAP;
                        end
                    endcase
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_d = POLL;
                end
            end
            POLL: begin
                if (tready_i) begin
                    issue    = 1'b1;
                    poll_inc = 1'b1;
                    state_d  = POLL_WAIT;
                end
            end
            POLL_WAIT: begin
                if (validflag_out_i) begin
                    rsp_data_d = {24'h0, data_out_i[7:0]};
                    if (!data_out_i[0]) begin
                        rsp_err_d = 1'b0;
                        state_d   = RESP;
                    end else if (poll_limit) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        fields_d = master_fields(state_d, op_d, addr_d, wdata_d, 4'(RD_DUMMY));
    end

    // State, latched request, master fields and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            fields_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fields_q   <= fields_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule
